wb_tia_objects: RTL and testbench
=================================

WB_TIA_OBJECTS -- requirements
Module: wb_tia_objects

Interface
REQ-001 SHALL have parameter WB_DATA_WIDTH, default 8, Wishbone data width (fixed at 8 for this block).
REQ-002 SHALL have parameter WB_ADDR_WIDTH, default 7, Wishbone address width.
REQ-003 SHALL have parameter NUM_OBJ, default 4, number of object channels; legal range 2..8.
REQ-004 SHALL have parameter H_VISIBLE, default 160, visible pixels per line.
REQ-005 SHALL have parameter H_TOTAL, default 228, pixel slots per line (H_TOTAL > H_VISIBLE).
REQ-006 clk_i  input  1  Sole clock; one clock for the whole block, all logic on rising edge.
REQ-007 rst_i  input  1  Reset, synchronous, active-high.
REQ-008 stb_i / we_i  input  1 / 1  Wishbone strobe / write enable.
REQ-009 adr_i / dat_i  input  WB_ADDR_WIDTH / 8  Wishbone address / write data.
REQ-010 ack_o / dat_o  output  1 / 8  Wishbone acknowledge / read data, both registered.
REQ-011 pix_en  input  1  Advance beam by one pixel slot this cycle.
REQ-012 pix_valid  output  1  pix_color holds a visible pixel.
REQ-013 pix_color  output  7  Colour index of current pixel.
REQ-014 line_end  output  1  One-cycle pulse when beam wraps to slot 0.
REQ-015 stall_cpu  output  1  High while a WSYNC is pending.

Function
REQ-016 ack_o SHALL be 1 in the cycle after any cycle with stb_i=1 and rst_i=0, and 0 otherwise; no wait states.
REQ-017 Register map (writes): 0x00 WSYNC, 0x01 HMOVE, 0x02 HMCLR, 0x03 CXCLR, 0x04 COLUBK[7:1]; object k at 0x10+4k: +0 GRPk, +1 COLk[7:1], +2 RESk (strobe), +3 HMk[3:0] (two's complement, -8..+7).
REQ-018 Reads SHALL return on dat_o in the ack cycle: 0x08+j = collision row j (bit i set = objects i and j overlapped), j<NUM_OBJ; all other addresses read 0; writes to unmapped addresses ignored.
REQ-019 Beam counter hpos SHALL increment on pix_en, wrapping from H_TOTAL-1 to 0; line_end SHALL pulse in the cycle after the wrap.
REQ-020 Object k SHALL hit when hpos in [x_k, x_k+7] and GRPk bit (7-(hpos-x_k)) is 1 (MSB drawn first); no horizontal wrap of the 8-pixel graphic.
REQ-021 pix_color SHALL be registered 1 cycle after pix_en: lowest-index hitting object's COLk, else COLUBK; pix_valid=1 iff that pix_en had hpos<H_VISIBLE.
REQ-022 On each visible pixel, every pair i!=j both hitting SHALL set cx[i][j] and cx[j][i]; bits are sticky until CXCLR or reset.
REQ-023 RESk SHALL load x_k with hpos as it was before any same-cycle increment, clamped to H_VISIBLE-1 when hpos>=H_VISIBLE.
REQ-024 HMOVE SHALL set every x_k to (x_k - HMk) mod H_VISIBLE in one cycle (positive HM moves left); HMCLR SHALL zero all HMk.
REQ-025 WSYNC SHALL raise stall_cpu next cycle, held until the next line_end; a WSYNC written in the wrap cycle SHALL hold until the following wrap.
REQ-026 CXCLR coincident with a collision set SHALL clear (clear wins).
REQ-027 RESk and HMOVE in the same cycle cannot occur (single port); HMOVE uses current HMk even if HMk is written later.

Reset
REQ-028 On rst_i: hpos=0, all x_k=0, GRPk=0, COLk=0, HMk=0, COLUBK=0, cx=0, stall_cpu=0, ack_o=0, dat_o=0, pix_valid=0, pix_color=0, line_end=0.
REQ-029 Reset mid-line or mid-WSYNC SHALL release stall_cpu and suppress ack_o for any strobe in the reset cycle.

Configuration
REQ-030 With WB_TIA_OBJECTS_REFLECT_EN defined, bit 4 of register +3 SHALL be REFk, stored with HMk; REFk=1 draws GRPk bit (hpos-x_k), LSB first; HMCLR SHALL NOT clear REFk.
REQ-031 Without WB_TIA_OBJECTS_REFLECT_EN, bit 4 SHALL be ignored and all objects draw MSB first.

Verification
REQ-032 Write GRP0=0x81, COL0=0x1E, RES0 at hpos=20 -> pix_color=0x0F at hpos 20 and 27, COLUBK colour at 21..26.
REQ-033 Objects 0 and 1 overlapping with GRP=0xFF at same x -> pixel shows COL0; read 0x08 returns 0x02, 0x09 returns 0x01; CXCLR then read -> 0x00.
REQ-034 x_0=3, HM0=0x7 then HMOVE -> x_0=156 (H_VISIBLE=160); HM0=0x8 (-8) -> x_0=11 from 3.
REQ-035 WSYNC at hpos=50 -> stall_cpu high from next cycle until the cycle after hpos wraps 227->0, coincident with line_end.
REQ-036 Assert rst_i during active WSYNC with collisions latched -> next cycle stall_cpu=0, all collision reads 0, ack_o=0.
REQ-037 With WB_TIA_OBJECTS_REFLECT_EN, GRP0=0x01, REF0=1 at x_0=10 -> object colour at hpos 10 only; without macro -> at hpos 17 only.

Source files
------------

// File: rtl/wb_tia_objects.sv
// -----------------------------------------------------------------------------
// wb_tia_objects
//
// A TIA-style object/playfield engine behind an 8-bit Wishbone slave port.
// A horizontal beam counter walks H_TOTAL pixel slots per line. On each slot,
// NUM_OBJ 8-pixel sprites are tested against the beam and the resulting colour
// is emitted one cycle later. Pairwise sprite overlaps on visible pixels latch
// into sticky collision bits. The CPU can be stalled until the end of the line
// (WSYNC), and sprites can be placed (RESk) or nudged (HMOVE).
//
// Optional feature macro: WB_TIA_OBJECTS_REFLECT_EN
//   When defined, bit 4 of each object's HMk register is REFk. REFk mirrors the
//   graphic so that it is drawn LSB first. When the macro is undefined, bit 4 is
//   ignored and every object is drawn MSB first.
//
// Write map:
//   0x00 WSYNC   0x01 HMOVE   0x02 HMCLR   0x03 CXCLR   0x04 COLUBK[7:1]
//   0x10+4k: +0 GRPk, +1 COLk[7:1], +2 RESk (strobe), +3 HMk[3:0] (+REFk bit 4)
// Read map:
//   0x08+j collision row j (bit i = objects i and j overlapped); others read 0
//
// Ports:
//   clk_i      sole clock, rising edge
//   rst_i      synchronous active-high reset
//   stb_i      Wishbone strobe
//   we_i       Wishbone write enable
//   adr_i      Wishbone address
//   dat_i      Wishbone write data
//   ack_o      registered acknowledge, one cycle after each strobe
//   dat_o      registered read data, valid in the ack cycle
//   pix_en     advance the beam by one pixel slot
//   pix_valid  pix_color holds a visible pixel
//   pix_color  7-bit colour index of the current pixel
//   line_end   one-cycle pulse after the beam wraps to slot 0
//   stall_cpu  high while a WSYNC is pending
// -----------------------------------------------------------------------------
module wb_tia_objects #(
  parameter int WB_DATA_WIDTH = 8,
  parameter int WB_ADDR_WIDTH = 7,
  parameter int NUM_OBJ       = 4,
  parameter int H_VISIBLE     = 160,
  parameter int H_TOTAL       = 228
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     stb_i,
  input  logic                     we_i,
  input  logic [WB_ADDR_WIDTH-1:0] adr_i,
  input  logic [WB_DATA_WIDTH-1:0] dat_i,
  output logic                     ack_o,
  output logic [WB_DATA_WIDTH-1:0] dat_o,
  input  logic                     pix_en,
  output logic                     pix_valid,
  output logic [6:0]               pix_color,
  output logic                     line_end,
  output logic                     stall_cpu
);

  localparam int HW = $clog2(H_TOTAL);

  localparam logic [WB_ADDR_WIDTH-1:0] A_WSYNC  = WB_ADDR_WIDTH'(8'h00);
  localparam logic [WB_ADDR_WIDTH-1:0] A_HMOVE  = WB_ADDR_WIDTH'(8'h01);
  localparam logic [WB_ADDR_WIDTH-1:0] A_HMCLR  = WB_ADDR_WIDTH'(8'h02);
  localparam logic [WB_ADDR_WIDTH-1:0] A_CXCLR  = WB_ADDR_WIDTH'(8'h03);
  localparam logic [WB_ADDR_WIDTH-1:0] A_COLUBK = WB_ADDR_WIDTH'(8'h04);

  // ---------------------------------------------------------------------------
  // Position arithmetic helpers
  // ---------------------------------------------------------------------------

  // HMOVE: x - hm, wrapped into [0, H_VISIBLE). x < H_VISIBLE and hm is in
  // -8..+7, so a single add or subtract of H_VISIBLE always suffices.
  function automatic logic [HW-1:0] f_hmove_wrap(input logic [HW-1:0] x,
                                                 input logic signed [3:0] hm);
    logic signed [HW+1:0] hm_ext;
    logic signed [HW+1:0] t;
    hm_ext = {{(HW-2){hm[3]}}, hm};
    t      = $signed({2'b00, x}) - hm_ext;
    if (t < 0)
      t = t + $signed((HW+2)'(H_VISIBLE));
    else if (t >= $signed((HW+2)'(H_VISIBLE)))
      t = t - $signed((HW+2)'(H_VISIBLE));
    return HW'(t);
  endfunction

  // RESk in horizontal blank parks the object at the last visible column.
  function automatic logic [HW-1:0] f_res_clamp(input logic [HW-1:0] h);
    if (h >= HW'(H_VISIBLE))
      return HW'(H_VISIBLE - 1);
    return h;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [HW-1:0]        r_hpos;
  logic [HW-1:0]        r_x   [NUM_OBJ];
  logic [7:0]           r_grp [NUM_OBJ];
  logic [6:0]           r_col [NUM_OBJ];
  logic signed [3:0]    r_hm  [NUM_OBJ];
  logic [NUM_OBJ-1:0]   r_cx  [NUM_OBJ];
  logic [6:0]           r_colubk;
  logic                 r_stall;
  logic                 r_ack;
  logic [7:0]           r_dat;
  logic                 r_pix_valid;
  logic [6:0]           r_pix_color;
  logic                 r_line_end;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic                 w_wr;
  logic                 w_wsync;
  logic                 w_hmove;
  logic                 w_hmclr;
  logic                 w_cxclr;
  logic                 w_colubk;
  logic [NUM_OBJ-1:0]   w_grp_we;
  logic [NUM_OBJ-1:0]   w_col_we;
  logic [NUM_OBJ-1:0]   w_res_we;
  logic [NUM_OBJ-1:0]   w_hm_we;
  logic [7:0]           w_rdata;

  assign w_wr     = stb_i & we_i & ~rst_i;
  assign w_wsync  = w_wr && (adr_i == A_WSYNC);
  assign w_hmove  = w_wr && (adr_i == A_HMOVE);
  assign w_hmclr  = w_wr && (adr_i == A_HMCLR);
  assign w_cxclr  = w_wr && (adr_i == A_CXCLR);
  assign w_colubk = w_wr && (adr_i == A_COLUBK);

  always_comb begin
    w_grp_we = '0;
    w_col_we = '0;
    w_res_we = '0;
    w_hm_we  = '0;
    for (int k = 0; k < NUM_OBJ; k++) begin
      if (adr_i == WB_ADDR_WIDTH'(16 + 4*k + 0)) w_grp_we[k] = w_wr;
      if (adr_i == WB_ADDR_WIDTH'(16 + 4*k + 1)) w_col_we[k] = w_wr;
      if (adr_i == WB_ADDR_WIDTH'(16 + 4*k + 2)) w_res_we[k] = w_wr;
      if (adr_i == WB_ADDR_WIDTH'(16 + 4*k + 3)) w_hm_we[k]  = w_wr;
    end
  end

  // Collision rows are the only readable registers.
  always_comb begin
    w_rdata = '0;
    for (int j = 0; j < NUM_OBJ; j++) begin
      if (adr_i == WB_ADDR_WIDTH'(8 + j))
        w_rdata[NUM_OBJ-1:0] = r_cx[j];
    end
  end

  // ---------------------------------------------------------------------------
  // Reflect bits (optional)
  // ---------------------------------------------------------------------------
  logic [NUM_OBJ-1:0] w_ref;

`ifdef WB_TIA_OBJECTS_REFLECT_EN
  logic [NUM_OBJ-1:0] r_ref;

  // REFk shares the HMk write but is deliberately untouched by HMCLR.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ref <= '0;
    end else begin
      for (int k = 0; k < NUM_OBJ; k++) begin
        if (w_hm_we[k]) r_ref[k] <= dat_i[4];
      end
    end
  end

  assign w_ref = r_ref;
`else
  assign w_ref = '0;
`endif

  // ---------------------------------------------------------------------------
  // Object hit test against the current (pre-increment) beam position
  // ---------------------------------------------------------------------------
  logic [NUM_OBJ-1:0] w_hit;
  logic [6:0]         w_color;
  logic               w_vis;
  logic               w_wrap;

  for (genvar k = 0; k < NUM_OBJ; k++) begin : g_hit
    logic [HW-1:0] w_off;
    logic [2:0]    w_bit;
    assign w_off    = r_hpos - r_x[k];
    // Normal drawing scans the graphic MSB first; reflected scans LSB first.
    assign w_bit    = w_ref[k] ? w_off[2:0] : (3'd7 - w_off[2:0]);
    // No horizontal wrap: the graphic only exists to the right of x_k.
    assign w_hit[k] = (r_hpos >= r_x[k]) && (w_off < HW'(8)) && r_grp[k][w_bit];
  end

  // Lowest-index object wins; iterate downward so it is assigned last.
  always_comb begin
    w_color = r_colubk;
    for (int k = NUM_OBJ - 1; k >= 0; k--) begin
      if (w_hit[k]) w_color = r_col[k];
    end
  end

  assign w_vis  = (r_hpos < HW'(H_VISIBLE));
  assign w_wrap = pix_en && (r_hpos == HW'(H_TOTAL - 1));

  // ---------------------------------------------------------------------------
  // Beam counter, pixel output and WSYNC stall
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_hpos      <= '0;
      r_pix_valid <= 1'b0;
      r_pix_color <= '0;
      r_line_end  <= 1'b0;
      r_stall     <= 1'b0;
    end else begin
      if (pix_en)
        r_hpos <= w_wrap ? '0 : r_hpos + HW'(1);
      r_pix_valid <= pix_en && w_vis;
      if (pix_en)
        r_pix_color <= w_color;
      r_line_end <= w_wrap;
      // A WSYNC landing on the wrap cycle waits for the following wrap.
      if (w_wsync)
        r_stall <= 1'b1;
      else if (w_wrap)
        r_stall <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Wishbone response
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= stb_i;
      r_dat <= (stb_i && !we_i) ? w_rdata : 8'h00;
    end
  end

  // ---------------------------------------------------------------------------
  // Object registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_colubk <= '0;
      for (int k = 0; k < NUM_OBJ; k++) begin
        r_x[k]   <= '0;
        r_grp[k] <= '0;
        r_col[k] <= '0;
        r_hm[k]  <= '0;
      end
    end else begin
      if (w_colubk) r_colubk <= dat_i[7:1];
      for (int k = 0; k < NUM_OBJ; k++) begin
        if (w_grp_we[k]) r_grp[k] <= dat_i[7:0];
        if (w_col_we[k]) r_col[k] <= dat_i[7:1];
        if (w_hm_we[k])
          r_hm[k] <= $signed(dat_i[3:0]);
        else if (w_hmclr)
          r_hm[k] <= '0;
        // RESk and HMOVE are distinct bus writes, so they never collide.
        if (w_res_we[k])
          r_x[k] <= f_res_clamp(r_hpos);
        else if (w_hmove)
          r_x[k] <= f_hmove_wrap(r_x[k], r_hm[k]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Collision latches: clear has priority over a same-cycle set
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i || w_cxclr) begin
      for (int j = 0; j < NUM_OBJ; j++) r_cx[j] <= '0;
    end else if (pix_en && w_vis) begin
      for (int j = 0; j < NUM_OBJ; j++) begin
        for (int i = 0; i < NUM_OBJ; i++) begin
          if (i != j && w_hit[i] && w_hit[j]) r_cx[j][i] <= 1'b1;
        end
      end
    end
  end

  assign ack_o     = r_ack;
  assign dat_o     = r_dat;
  assign pix_valid = r_pix_valid;
  assign pix_color = r_pix_color;
  assign line_end  = r_line_end;
  assign stall_cpu = r_stall;

endmodule

// File: tb/tb_wb_tia_objects.sv
// -----------------------------------------------------------------------------
// tb_wb_tia_objects
//
// Bench for wb_tia_objects. A behavioural model of the beam, objects and
// registers is stepped alongside the DUT one cycle at a time; directed
// scenarios also compare against hand-derived constants.
// -----------------------------------------------------------------------------
module tb_wb_tia_objects;

  localparam int NOBJ = 4;
  localparam int HV   = 160;
  localparam int HT   = 228;
`ifdef WB_TIA_OBJECTS_REFLECT_EN
  localparam bit REFL = 1'b1;
`else
  localparam bit REFL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_i, stb_i, we_i, pix_en;
  logic [6:0] adr_i;
  logic [7:0] dat_i;
  logic       ack_o;
  logic [7:0] dat_o;
  logic       pix_valid;
  logic [6:0] pix_color;
  logic       line_end, stall_cpu;

  always #5 clk = ~clk;

  wb_tia_objects #(
    .WB_DATA_WIDTH(8), .WB_ADDR_WIDTH(7), .NUM_OBJ(NOBJ),
    .H_VISIBLE(HV), .H_TOTAL(HT)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .stb_i(stb_i), .we_i(we_i),
    .adr_i(adr_i), .dat_i(dat_i), .ack_o(ack_o), .dat_o(dat_o),
    .pix_en(pix_en), .pix_valid(pix_valid), .pix_color(pix_color),
    .line_end(line_end), .stall_cpu(stall_cpu)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model state
  int m_h;
  int m_x   [NOBJ];
  int m_grp [NOBJ];
  int m_col [NOBJ];
  int m_hm  [NOBJ];
  bit m_ref [NOBJ];
  bit m_cx  [NOBJ][NOBJ];
  int m_bk;
  bit m_stall;
  int last_h;

  logic       e_ack, e_pv, e_le, e_st;
  logic [7:0] e_dat;
  logic [6:0] e_pc;

  function automatic bit obj_hit(int k, int h);
    int d, idx;
    d = h - m_x[k];
    if (d < 0 || d > 7) return 1'b0;
    idx = (REFL && m_ref[k]) ? d : 7 - d;
    return ((m_grp[k] >> idx) & 1) != 0;
  endfunction

  function automatic logic [7:0] read_val(int a);
    int v;
    v = 0;
    if (a >= 8 && a < 8 + NOBJ)
      for (int i = 0; i < NOBJ; i++) if (m_cx[a-8][i]) v += (1 << i);
    return 8'(v);
  endfunction

  task automatic model_reset();
    m_h = 0; m_bk = 0; m_stall = 0;
    for (int k = 0; k < NOBJ; k++) begin
      m_x[k] = 0; m_grp[k] = 0; m_col[k] = 0; m_hm[k] = 0; m_ref[k] = 0;
      for (int j = 0; j < NOBJ; j++) m_cx[k][j] = 0;
    end
  endtask

  // Drive one cycle, advance the model, and sample #1 after the edge.
  task automatic cyc(input bit r, input bit s, input bit w, input int a,
                     input int d, input bit p);
    bit hit [NOBJ];
    bit wsync;
    rst_i = r; stb_i = s; we_i = w; adr_i = 7'(a); dat_i = 8'(d); pix_en = p;
    last_h = m_h;
    if (r) begin
      model_reset();
      e_ack = 0; e_dat = 0; e_pv = 0; e_pc = 0; e_le = 0;
    end else begin
      wsync = 0;
      for (int k = 0; k < NOBJ; k++) hit[k] = obj_hit(k, m_h);
      e_ack = s;
      e_dat = (s && !w) ? read_val(a) : 8'h00;
      e_pv  = p && (m_h < HV);
      e_le  = p && (m_h == HT - 1);
      if (p) begin
        e_pc = 7'(m_bk);
        for (int k = NOBJ - 1; k >= 0; k--) if (hit[k]) e_pc = 7'(m_col[k]);
      end
      if (p && m_h < HV)
        for (int i = 0; i < NOBJ; i++)
          for (int j = 0; j < NOBJ; j++)
            if (i != j && hit[i] && hit[j]) m_cx[i][j] = 1;
      if (s && w) begin
        if (a == 0) wsync = 1;
        else if (a == 1) begin
          for (int k = 0; k < NOBJ; k++) m_x[k] = ((m_x[k] - m_hm[k]) % HV + HV) % HV;
        end
        else if (a == 2) begin
          for (int k = 0; k < NOBJ; k++) m_hm[k] = 0;
        end
        else if (a == 3) begin
          for (int i = 0; i < NOBJ; i++) for (int j = 0; j < NOBJ; j++) m_cx[i][j] = 0;
        end
        else if (a == 4) m_bk = (d % 256) / 2;
        else if (a >= 16 && a < 16 + 4*NOBJ) begin
          case ((a - 16) % 4)
            0: m_grp[(a-16)/4] = d % 256;
            1: m_col[(a-16)/4] = (d % 256) / 2;
            2: m_x[(a-16)/4]   = (m_h >= HV) ? HV - 1 : m_h;
            default: begin
              m_hm[(a-16)/4]  = ((d % 16) >= 8) ? (d % 16) - 16 : (d % 16);
              m_ref[(a-16)/4] = ((d / 16) % 2) == 1;
            end
          endcase
        end
      end
      if (wsync) m_stall = 1;
      else if (p && m_h == HT - 1) m_stall = 0;
      if (p) m_h = (m_h + 1) % HT;
    end
    e_st = m_stall;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int d);
    cyc(0, 1, 1, a, d, 0);
  endtask

  task automatic rd(input int a);
    cyc(0, 1, 0, a, 0, 0);
  endtask

  task automatic goto_h(input int h);
    for (int c = 0; c < HT && m_h != h; c++) cyc(0, 0, 0, 0, 0, 1);
  endtask

  // One full line of pixels; gathers where the target colour appears and how
  // many cycles disagreed with the model.
  task automatic scan_line(input logic [6:0] tgt, output int first,
                           output int hits, output int bad);
    first = -1; hits = 0; bad = 0;
    for (int c = 0; c < HT; c++) begin
      cyc(0, 0, 0, 0, 0, 1);
      if (pix_color !== e_pc || pix_valid !== e_pv || line_end !== e_le) bad++;
      if (pix_color === tgt) begin
        hits++;
        if (first < 0 || last_h < first) first = last_h;
      end
    end
  endtask

  task automatic test_reset();
    cyc(1, 1, 0, 8, 0, 1);
    n_checks++; if (ack_o !== 1'b0) $display("FAIL reset_ack got=%b want=0", ack_o); else n_pass++;
    n_checks++; if (dat_o !== 8'h00) $display("FAIL reset_dat got=%h want=00", dat_o); else n_pass++;
    n_checks++; if (pix_valid !== 1'b0) $display("FAIL reset_pv got=%b want=0", pix_valid); else n_pass++;
    n_checks++; if (pix_color !== 7'h00) $display("FAIL reset_pc got=%h want=00", pix_color); else n_pass++;
    n_checks++; if (line_end !== 1'b0) $display("FAIL reset_le got=%b want=0", line_end); else n_pass++;
    n_checks++; if (stall_cpu !== 1'b0) $display("FAIL reset_stall got=%b want=0", stall_cpu); else n_pass++;
  endtask

  task automatic test_grp_draw();
    int bad;
    bad = 0;
    wr(4, 'h44); wr('h10, 'h81); wr('h11, 'h1E);
    goto_h(20);
    wr('h12, 0);
    for (int c = 0; c < HT; c++) begin
      cyc(0, 0, 0, 0, 0, 1);
      if (pix_color !== e_pc || pix_valid !== e_pv) bad++;
      if (last_h == 20 || last_h == 27) begin
        n_checks++;
        if (pix_color !== 7'h0F) $display("FAIL grp_edge h=%0d got=%h want=0f", last_h, pix_color);
        else n_pass++;
      end
      if (last_h == 21 || last_h == 26) begin
        n_checks++;
        if (pix_color !== 7'h22) $display("FAIL grp_gap h=%0d got=%h want=22", last_h, pix_color);
        else n_pass++;
      end
    end
    n_checks++; if (bad !== 0) $display("FAIL grp_line_model bad=%0d want=0", bad); else n_pass++;
  endtask

  task automatic test_collision();
    int first, hits, bad;
    wr('h10, 'hFF); wr('h14, 'hFF); wr('h15, 'h2A);
    goto_h(40);
    wr('h12, 0); wr('h16, 0);
    scan_line(7'h15, first, hits, bad);
    n_checks++; if (hits !== 0) $display("FAIL cx_col1_shown hits=%0d want=0", hits); else n_pass++;
    n_checks++; if (bad !== 0) $display("FAIL cx_line_model bad=%0d want=0", bad); else n_pass++;
    rd(8);
    n_checks++; if (ack_o !== 1'b1) $display("FAIL cx_ack got=%b want=1", ack_o); else n_pass++;
    n_checks++; if (dat_o !== 8'h02) $display("FAIL cx_row0 got=%h want=02", dat_o); else n_pass++;
    rd(9);
    n_checks++; if (dat_o !== 8'h01) $display("FAIL cx_row1 got=%h want=01", dat_o); else n_pass++;
    rd(10);
    n_checks++; if (dat_o !== 8'h00) $display("FAIL cx_row2 got=%h want=00", dat_o); else n_pass++;
    wr(3, 0);
    rd(8);
    n_checks++; if (dat_o !== 8'h00) $display("FAIL cx_clr_row0 got=%h want=00", dat_o); else n_pass++;
    rd(9);
    n_checks++; if (dat_o !== 8'h00) $display("FAIL cx_clr_row1 got=%h want=00", dat_o); else n_pass++;
  endtask

  task automatic test_hmove();
    int first, hits, bad;
    wr('h14, 0);
    goto_h(3); wr('h12, 0); wr('h13, 'h07); wr(1, 0);
    scan_line(7'h0F, first, hits, bad);
    n_checks++; if (first !== 156) $display("FAIL hmove_plus7 x=%0d want=156", first); else n_pass++;
    n_checks++; if (bad !== 0) $display("FAIL hmove_model bad=%0d want=0", bad); else n_pass++;
    goto_h(3); wr('h12, 0); wr('h13, 'h08); wr(1, 0);
    scan_line(7'h0F, first, hits, bad);
    n_checks++; if (first !== 11) $display("FAIL hmove_minus8 x=%0d want=11", first); else n_pass++;
    n_checks++; if (hits !== 8) $display("FAIL hmove_width hits=%0d want=8", hits); else n_pass++;
    wr(2, 0); wr(1, 0);
    scan_line(7'h0F, first, hits, bad);
    n_checks++; if (first !== 11) $display("FAIL hmclr_x x=%0d want=11", first); else n_pass++;
  endtask

  task automatic test_wsync();
    int hi, seen;
    goto_h(50);
    cyc(0, 1, 1, 0, 0, 1);
    n_checks++; if (stall_cpu !== 1'b1) $display("FAIL wsync_rise got=%b want=1", stall_cpu); else n_pass++;
    hi = 1; seen = 0;
    for (int c = 0; c < HT + 10 && !seen; c++) begin
      cyc(0, 0, 0, 0, 0, 1);
      if (line_end === 1'b1) seen = 1;
      else if (stall_cpu === 1'b1) hi++;
    end
    n_checks++; if (seen !== 1) $display("FAIL wsync_timeout line_end never seen"); else n_pass++;
    n_checks++; if (stall_cpu !== 1'b0) $display("FAIL wsync_fall got=%b want=0", stall_cpu); else n_pass++;
    n_checks++; if (last_h !== 227) $display("FAIL wsync_wrap_h got=%0d want=227", last_h); else n_pass++;
    n_checks++; if (hi !== 177) $display("FAIL wsync_len got=%0d want=177", hi); else n_pass++;
    goto_h(227);
    cyc(0, 1, 1, 0, 0, 1);
    n_checks++;
    if (stall_cpu !== 1'b1 || line_end !== 1'b1)
      $display("FAIL wsync_at_wrap stall=%b le=%b want=1 1", stall_cpu, line_end);
    else n_pass++;
    hi = 0; seen = 0;
    for (int c = 0; c < HT + 10 && !seen; c++) begin
      cyc(0, 0, 0, 0, 0, 1);
      if (line_end === 1'b1) seen = 1;
      else if (stall_cpu === 1'b1) hi++;
    end
    n_checks++;
    if (seen !== 1 || stall_cpu !== 1'b0 || hi !== 227)
      $display("FAIL wsync_wrap_hold seen=%0d stall=%b len=%0d want=1 0 227", seen, stall_cpu, hi);
    else n_pass++;
  endtask

  task automatic test_reflect();
    int first, hits, bad;
    wr(4, 'h44); wr('h10, 'h01); wr('h11, 'h1E);
    for (int k = 1; k < NOBJ; k++) wr('h10 + 4*k, 0);
    goto_h(10); wr('h12, 0); wr('h13, 'h10);
    scan_line(7'h0F, first, hits, bad);
    n_checks++;
    if (first !== (REFL ? 10 : 17)) $display("FAIL reflect_pos got=%0d want=%0d", first, REFL ? 10 : 17);
    else n_pass++;
    n_checks++; if (hits !== 1) $display("FAIL reflect_hits got=%0d want=1", hits); else n_pass++;
    n_checks++; if (bad !== 0) $display("FAIL reflect_model bad=%0d want=0", bad); else n_pass++;
  endtask

  task automatic test_random();
    int a, sel;
    for (int c = 0; c < 1500; c++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0: a = $urandom_range(0, 7);
        1: a = 8 + $urandom_range(0, 7);
        2: a = 16 + $urandom_range(0, 4*NOBJ - 1);
        default: a = $urandom_range(0, 127);
      endcase
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
          a, $urandom_range(0, 255), $urandom_range(0, 3) != 0);
      n_checks++; if (ack_o !== e_ack) $display("FAIL rnd_ack c=%0d got=%b want=%b", c, ack_o, e_ack); else n_pass++;
      n_checks++; if (dat_o !== e_dat) $display("FAIL rnd_dat c=%0d got=%h want=%h", c, dat_o, e_dat); else n_pass++;
      n_checks++; if (pix_valid !== e_pv) $display("FAIL rnd_pv c=%0d got=%b want=%b", c, pix_valid, e_pv); else n_pass++;
      n_checks++; if (pix_color !== e_pc) $display("FAIL rnd_pc c=%0d got=%h want=%h", c, pix_color, e_pc); else n_pass++;
      n_checks++; if (line_end !== e_le) $display("FAIL rnd_le c=%0d got=%b want=%b", c, line_end, e_le); else n_pass++;
      n_checks++; if (stall_cpu !== e_st) $display("FAIL rnd_stall c=%0d got=%b want=%b", c, stall_cpu, e_st); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    wr(3, 0);
    wr('h10, 'hFF); wr('h14, 'hFF);
    goto_h(60); wr('h12, 0); wr('h16, 0);
    goto_h(70);
    rd(8);
    n_checks++; if (dat_o !== 8'h02) $display("FAIL rstmid_pre_cx got=%h want=02", dat_o); else n_pass++;
    wr(0, 0);
    n_checks++; if (stall_cpu !== 1'b1) $display("FAIL rstmid_pre_stall got=%b want=1", stall_cpu); else n_pass++;
    cyc(1, 1, 0, 8, 0, 1);
    n_checks++; if (stall_cpu !== 1'b0) $display("FAIL rstmid_stall got=%b want=0", stall_cpu); else n_pass++;
    n_checks++; if (ack_o !== 1'b0) $display("FAIL rstmid_ack got=%b want=0", ack_o); else n_pass++;
    for (int j = 0; j < NOBJ; j++) begin
      rd(8 + j);
      n_checks++;
      if (dat_o !== 8'h00 || ack_o !== 1'b1)
        $display("FAIL rstmid_cx row=%0d got=%h ack=%b want=00 1", j, dat_o, ack_o);
      else n_pass++;
    end
  endtask

  initial begin
    rst_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; adr_i = '0; dat_i = '0; pix_en = 1'b0;
    model_reset();
    test_reset();
    test_grp_draw();
    test_collision();
    test_hmove();
    test_wsync();
    test_reflect();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

endmodule
